// File: rtl/wb_master_arbiter.sv
// Round-robin arbiter sharing one Wishbone-style bus master port among N CPU-side masters.
// One transaction per grant, acknowledge routed to the granted master, watchdog for silent slaves.
module wb_master_arbiter #(
    parameter int N_MASTERS = 4,
    parameter int TIMEOUT   = 1023
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [32*N_MASTERS-1:0]   io_masters_addr,
    input  logic [32*N_MASTERS-1:0]   io_masters_dat2,
    input  logic [N_MASTERS-1:0]      io_masters_sel,
    input  logic [N_MASTERS-1:0]      io_masters_we,
    output logic [31:0]               io_masters_dat4,
    output logic [N_MASTERS-1:0]      io_masters_ack,
    output logic [N_MASTERS-1:0]      io_masters_err,
    output logic [31:0]               io_to_bus_addr,
    output logic [31:0]               io_to_bus_dat2,
    output logic                      io_to_bus_sel,
    output logic                      io_to_bus_we,
    input  logic [31:0]               io_to_bus_dat4,
    input  logic                      io_to_bus_ack,
    output logic [2:0]                io_grant
);

    localparam int          GW        = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
    localparam bit          WDOG_EN   = (TIMEOUT != 0);
    localparam logic [15:0] WDOG_LAST = 16'(TIMEOUT - 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t          state_reg, state_next;
    logic [GW-1:0]   grant_reg, grant_next;
    logic [GW-1:0]   last_reg, last_next;
    logic [15:0]     wdog_reg, wdog_next;

    logic [31:0]     addr_arr [N_MASTERS];
    logic [31:0]     dat2_arr [N_MASTERS];
    logic [GW-1:0]   rr_pick;
    logic            rr_found;
    logic            grant_sel;
    logic            timeout_hit;

    generate
        for (genvar gi = 0; gi < N_MASTERS; gi++) begin : g_unpack
            assign addr_arr[gi] = io_masters_addr[32*gi +: 32];
            assign dat2_arr[gi] = io_masters_dat2[32*gi +: 32];
        end
    endgenerate

    // Priority starts just above the last winner, then wraps to the low indices.
    always_comb begin
        rr_pick  = last_reg;
        rr_found = 1'b0;
        for (int i = 0; i < N_MASTERS; i++) begin
            if (!rr_found && io_masters_sel[i] && (i > int'(last_reg))) begin
                rr_found = 1'b1;
                rr_pick  = GW'(i);
            end
        end
        for (int i = 0; i < N_MASTERS; i++) begin
            if (!rr_found && io_masters_sel[i] && (i <= int'(last_reg))) begin
                rr_found = 1'b1;
                rr_pick  = GW'(i);
            end
        end
    end

    assign grant_sel   = io_masters_sel[grant_reg];
    assign timeout_hit = WDOG_EN && (wdog_reg == WDOG_LAST);

    always_comb begin
        state_next     = state_reg;
        grant_next     = grant_reg;
        last_next      = last_reg;
        wdog_next      = wdog_reg;
        io_to_bus_addr = 32'd0;
        io_to_bus_dat2 = 32'd0;
        io_to_bus_we   = 1'b0;
        io_to_bus_sel  = 1'b0;
        io_masters_ack = '0;
        io_masters_err = '0;
        case (state_reg)
            IDLE: begin
                if (rr_found) begin
                    grant_next = rr_pick;
                    last_next  = rr_pick;
                    wdog_next  = 16'd0;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                io_to_bus_addr = addr_arr[grant_reg];
                io_to_bus_dat2 = dat2_arr[grant_reg];
                io_to_bus_we   = io_masters_we[grant_reg];
                // An ack in the watchdog's final cycle still completes normally.
                io_to_bus_sel  = grant_sel && !(timeout_hit && !io_to_bus_ack);
                if (grant_sel && io_to_bus_ack) begin
                    io_masters_ack[grant_reg] = 1'b1;
                end else if (grant_sel && timeout_hit) begin
                    io_masters_err[grant_reg] = 1'b1;
                end
                if (!grant_sel || io_to_bus_ack || timeout_hit) begin
                    state_next = IDLE;
                    wdog_next  = 16'd0;
                end else if (wdog_reg != 16'hFFFF) begin
                    wdog_next = wdog_reg + 16'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            grant_reg <= '0;
            last_reg  <= GW'(N_MASTERS - 1);
            wdog_reg  <= 16'd0;
        end else begin
            state_reg <= state_next;
            grant_reg <= grant_next;
            last_reg  <= last_next;
            wdog_reg  <= wdog_next;
        end
    end

    assign io_masters_dat4 = io_to_bus_dat4;
    assign io_grant        = 3'(grant_reg);

endmodule

// File: tb/tb_wb_master_arbiter.sv
// Bench for wb_master_arbiter: directed scenarios followed by random traffic, every cycle
// checked against a transaction-level round-robin model built on a priority queue.
module tb_wb_master_arbiter;

    localparam int NM  = 4;
    localparam int TMO = 8;

    logic              clk;
    logic              reset;
    logic [32*NM-1:0]  addr_p, dat2_p;
    logic [NM-1:0]     sel_v, we_v;
    logic [31:0]       addr_v [NM];
    logic [31:0]       dat2_v [NM];
    logic [31:0]       m_dat4;
    logic [NM-1:0]     m_ack, m_err;
    logic [31:0]       bus_addr, bus_dat2, bus_dat4_v;
    logic              bus_sel, bus_we, bus_ack_v;
    logic [2:0]        grant;

    wb_master_arbiter #(.N_MASTERS(NM), .TIMEOUT(TMO)) dut (
        .clk             (clk),
        .reset           (reset),
        .io_masters_addr (addr_p),
        .io_masters_dat2 (dat2_p),
        .io_masters_sel  (sel_v),
        .io_masters_we   (we_v),
        .io_masters_dat4 (m_dat4),
        .io_masters_ack  (m_ack),
        .io_masters_err  (m_err),
        .io_to_bus_addr  (bus_addr),
        .io_to_bus_dat2  (bus_dat2),
        .io_to_bus_sel   (bus_sel),
        .io_to_bus_we    (bus_we),
        .io_to_bus_dat4  (bus_dat4_v),
        .io_to_bus_ack   (bus_ack_v),
        .io_grant        (grant)
    );

    always_comb begin
        for (int i = 0; i < NM; i++) begin
            addr_p[32*i +: 32] = addr_v[i];
            dat2_p[32*i +: 32] = dat2_v[i];
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: priority order as a queue, the most recent winner at the back.
    bit         m_busy;
    int         m_grant;
    int         m_cnt;
    int         rr_q[$];
    logic [3:0] done_mask;
    int         sel_hi_cnt;
    int         ack_cnt [NM];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_busy    = 1'b0;
        m_grant   = 0;
        m_cnt     = 0;
        rr_q      = {0, 1, 2, 3};
        done_mask = 4'b0;
    endtask

    // Inputs are already driven (just after a rising edge); check this cycle, advance the model.
    task automatic step();
        logic [3:0]  e_ack, e_err;
        logic        e_sel, e_we;
        logic [31:0] e_addr, e_dat2;
        bit          s, tmo, fin;
        int          g;
        #1;
        e_ack = 4'b0; e_err = 4'b0; e_sel = 1'b0; e_we = 1'b0;
        e_addr = 32'd0; e_dat2 = 32'd0; fin = 1'b0; g = -1;
        if (m_busy) begin
            s      = sel_v[m_grant];
            tmo    = (TMO != 0) && (m_cnt == TMO - 1);
            e_addr = addr_v[m_grant];
            e_dat2 = dat2_v[m_grant];
            e_we   = we_v[m_grant];
            if (s && bus_ack_v)  e_ack[m_grant] = 1'b1;
            else if (s && tmo)   e_err[m_grant] = 1'b1;
            e_sel  = s && !e_err[m_grant];
            fin    = !s || bus_ack_v || tmo;
        end
        chk("bus_sel",  32'(bus_sel),  32'(e_sel));
        chk("bus_we",   32'(bus_we),   32'(e_we));
        chk("bus_addr", bus_addr,      e_addr);
        chk("bus_dat2", bus_dat2,      e_dat2);
        chk("m_ack",    32'(m_ack),    32'(e_ack));
        chk("m_err",    32'(m_err),    32'(e_err));
        chk("m_dat4",   m_dat4,        bus_dat4_v);
        chk("grant",    32'(grant),    32'(m_grant));
        if (bus_sel) sel_hi_cnt++;
        for (int i = 0; i < NM; i++) if (m_ack[i]) ack_cnt[i]++;
        done_mask = e_ack | e_err;
        if (m_busy) begin
            if (fin) m_busy = 1'b0;
            else     m_cnt++;
        end else if (|sel_v) begin
            foreach (rr_q[k]) if (g < 0 && sel_v[rr_q[k]]) g = rr_q[k];
            m_grant = g;
            m_busy  = 1'b1;
            m_cnt   = 0;
            while (rr_q[$] != g) rr_q.push_back(rr_q.pop_front());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0; sel_v = 4'b0; we_v = 4'b0; bus_ack_v = 1'b0; bus_dat4_v = 32'd0;
        for (int i = 0; i < NM; i++) begin
            addr_v[i] = 32'h1000_0000 + 32'(i * 16);
            dat2_v[i] = 32'hA000_0000 + 32'(i);
        end
        model_reset();
        sel_hi_cnt = 0;
        for (int i = 0; i < NM; i++) ack_cnt[i] = 0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_grant", 32'(grant),   32'd0);
        chk("rst_sel",   32'(bus_sel), 32'd0);
        chk("rst_we",    32'(bus_we),  32'd0);
        chk("rst_addr",  bus_addr,     32'd0);
        chk("rst_dat2",  bus_dat2,     32'd0);
        chk("rst_ack",   32'(m_ack),   32'd0);
        chk("rst_err",   32'(m_err),   32'd0);
        reset = 1'b1;

        // All four masters request continuously, bus acks every cycle
        sel_v = 4'hF; bus_ack_v = 1'b1;
        for (int t = 0; t < 6; t++) begin
            step();
            chk("rr_order",  32'(grant),   32'(t % 4));
            chk("rr_sel_hi", 32'(bus_sel), 32'd1);
            step();
            chk("rr_sel_gap", 32'(bus_sel), 32'd0);
        end
        sel_v = 4'b0; bus_ack_v = 1'b0;
        step();

        // Master 2 read, ack on third BUSY cycle
        sel_hi_cnt = 0;
        for (int i = 0; i < NM; i++) ack_cnt[i] = 0;
        addr_v[2] = 32'h8000_0010; we_v[2] = 1'b0; sel_v = 4'b0100;
        step();
        chk("m2_grant", 32'(grant), 32'd2);
        step();
        step();
        bus_ack_v = 1'b1; bus_dat4_v = 32'h1234_5678;
        #1;
        chk("m2_dat4", m_dat4,       32'h1234_5678);
        chk("m2_ack",  32'(m_ack),   32'b0100);
        step();
        sel_v = 4'b0; bus_ack_v = 1'b0;
        step();
        chk("m2_sel_cycles", 32'(sel_hi_cnt), 32'd3);
        chk("m2_ack_pulses", 32'(ack_cnt[2]), 32'd1);
        chk("m2_other_acks", 32'(ack_cnt[0] + ack_cnt[1] + ack_cnt[3]), 32'd0);

        // Grant to 1, then 0 and 3 request: 3 goes first
        sel_v = 4'b0010; bus_ack_v = 1'b1;
        step();
        step();
        sel_v = 4'b1001;
        step();
        chk("rr_3_first", 32'(grant), 32'd3);
        step();
        sel_v = 4'b0001;
        step();
        chk("rr_0_next", 32'(grant), 32'd0);
        step();
        sel_v = 4'b0; bus_ack_v = 1'b0;
        step();

        // Watchdog: master 1 write never acknowledged
        sel_v = 4'b0010; we_v[1] = 1'b1; addr_v[1] = 32'hDEAD_0000;
        step();
        chk("to_grant", 32'(grant), 32'd1);
        for (int b = 1; b < TMO; b++) step();
        #1;
        chk("to_err", 32'(m_err),   32'b0010);
        chk("to_sel", 32'(bus_sel), 32'd0);
        chk("to_ack", 32'(m_ack),   32'd0);
        step();
        sel_v = 4'b0001;
        step();
        chk("to_next_grant", 32'(grant), 32'd0);
        bus_ack_v = 1'b1;
        step();
        sel_v = 4'b0; bus_ack_v = 1'b0;
        step();

        // Master 2 abandons in its second BUSY cycle, master 3 pending
        sel_v = 4'b1100;
        step();
        chk("ab_grant2", 32'(grant), 32'd2);
        step();
        sel_v = 4'b1000;
        #1;
        chk("ab_ack", 32'(m_ack), 32'd0);
        chk("ab_err", 32'(m_err), 32'd0);
        step();
        step();
        chk("ab_grant3", 32'(grant), 32'd3);
        bus_ack_v = 1'b1;
        step();
        sel_v = 4'b0; bus_ack_v = 1'b0;
        step();

        // Reset asserted while master 0 is writing
        sel_v = 4'b0011; we_v[0] = 1'b1; we_v[1] = 1'b0;
        step();
        #2;
        reset = 1'b0;
        #1;
        chk("rb_sel", 32'(bus_sel), 32'd0);
        chk("rb_we",  32'(bus_we),  32'd0);
        chk("rb_ack", 32'(m_ack),   32'd0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        step();
        chk("rb_grant0", 32'(grant), 32'd0);
        bus_ack_v = 1'b1;
        step();
        sel_v = 4'b0; bus_ack_v = 1'b0;
        step();

        // Random traffic against the model
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NM; i++) begin
                if (done_mask[i]) begin
                    if ($urandom_range(0, 1) == 0) begin
                        sel_v[i] = 1'b0;
                    end else begin
                        addr_v[i] = $urandom();
                        dat2_v[i] = $urandom();
                        we_v[i]   = 1'($urandom_range(0, 1));
                    end
                end else if (!sel_v[i] && $urandom_range(0, 3) == 0) begin
                    sel_v[i]  = 1'b1;
                    addr_v[i] = $urandom();
                    dat2_v[i] = $urandom();
                    we_v[i]   = 1'($urandom_range(0, 1));
                end else if (sel_v[i] && $urandom_range(0, 31) == 0) begin
                    sel_v[i] = 1'b0;
                end
            end
            bus_ack_v  = ($urandom_range(0, 9) < 3);
            bus_dat4_v = $urandom();
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
